tcp_rx_conn_ctrl: RTL and testbench

Single-connection TCP receive controller that sits directly after `tcp_handler` on its metadata interface. It consumes one metadata record per received segment and runs a passive-open / passive-close connection state machine. It decides whether the already-forwarded payload is committed or dropped by the downstream payload FIFO, and issues ACK/SYN-ACK/FIN-ACK transmit requests to the TX segment builder.

---
 rtl/tcp_ctrl_pkg.sv | 29 ++
 rtl/tcp_tx_req_slot.sv | 32 +++
 rtl/tcp_rx_conn_ctrl.sv | 178 +++++++++++++++++
 tb/tb_tcp_rx_conn_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tcp_ctrl_pkg.sv
// Shared types and constants for the TCP receive connection controller.
package tcp_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_LISTEN      = 3'd0,
    ST_SYN_RCVD    = 3'd1,
    ST_ESTABLISHED = 3'd2,
    ST_LAST_ACK    = 3'd3
  } conn_state_t;

  // Bit positions inside the 8-bit TCP flags field.
  localparam int TCP_FLAG_FIN = 0;
  localparam int TCP_FLAG_SYN = 1;
  localparam int TCP_FLAG_RST = 2;
  localparam int TCP_FLAG_ACK = 4;

  localparam logic [7:0] FLAGS_ACK    = 8'h10;
  localparam logic [7:0] FLAGS_SYNACK = 8'h12;
  localparam logic [7:0] FLAGS_FINACK = 8'h11;

  // One transmit request as handed to the TX segment builder.
  typedef struct packed {
    logic [7:0]  flags;
    logic [31:0] seq;
    logic [31:0] ack;
    logic [15:0] dst_port;
  } tx_req_t;

endpackage

// File: rtl/tcp_tx_req_slot.sv
// One-entry valid/ready holding register for outgoing TX requests.
import tcp_ctrl_pkg::*;

module tcp_tx_req_slot (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    push,
  input  tx_req_t push_req,
  output logic    valid,
  input  logic    ready,
  output tx_req_t req,
  output logic    empty
);

  // Load a request when empty; release it on the edge the consumer accepts it.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      req   <= '0;
    end else if (push && !valid) begin
      valid <= 1'b1;
      req   <= push_req;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

  assign empty = !valid;

endmodule

// File: rtl/tcp_rx_conn_ctrl.sv
// Single-connection passive-open/passive-close TCP receive controller.
import tcp_ctrl_pkg::*;

module tcp_rx_conn_ctrl #(
  parameter logic [15:0] LOCAL_PORT = 16'd80,
  parameter logic [31:0] ISS        = 32'h0000_1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        meta_valid,
  output logic        meta_ready,
  input  logic [15:0] meta_src_port,
  input  logic [15:0] meta_dst_port,
  input  logic [31:0] meta_seq_num,
  input  logic [31:0] meta_ack_num,
  input  logic [7:0]  meta_flags,
  input  logic [15:0] meta_window_size,
  input  logic [15:0] meta_payload_len,
  output logic        pkt_commit,
  output logic        pkt_drop,
  output logic        tx_req_valid,
  input  logic        tx_req_ready,
  output logic [7:0]  tx_flags,
  output logic [31:0] tx_seq,
  output logic [31:0] tx_ack,
  output logic [15:0] tx_dst_port,
  output logic [2:0]  conn_state,
  output logic [31:0] rcv_nxt,
  output logic [15:0] peer_window
);

  conn_state_t state, nxt_state;
  logic [31:0] rcv_nxt_q, snd_nxt_q, nxt_rcv_nxt, nxt_snd_nxt, rcv_after;
  logic [15:0] peer_port_q, peer_window_q, nxt_peer_port, nxt_peer_window;
  logic        do_commit, tx_push, data_step, slot_empty, accept;
  tx_req_t     tx_new, tx_cur;

  logic f_fin, f_syn, f_rst, f_ack;
  logic seg_ok, in_order, ack_match, state_legal;
  logic unused_flag_bits;

  assign f_fin = meta_flags[TCP_FLAG_FIN];
  assign f_syn = meta_flags[TCP_FLAG_SYN];
  assign f_rst = meta_flags[TCP_FLAG_RST];
  assign f_ack = meta_flags[TCP_FLAG_ACK];
  assign unused_flag_bits = ^{meta_flags[7:5], meta_flags[3]};

  // Records are consumed only while the TX slot is free, so a request is never lost.
  assign meta_ready = rst_n && slot_empty;
  assign accept     = meta_valid && meta_ready;

  assign state_legal = (state == ST_LISTEN) || (state == ST_SYN_RCVD) ||
                       (state == ST_ESTABLISHED) || (state == ST_LAST_ACK);
  assign seg_ok    = (meta_dst_port == LOCAL_PORT) &&
                     ((state == ST_LISTEN) || (meta_src_port == peer_port_q));
  assign in_order  = (meta_seq_num == rcv_nxt_q);
  assign ack_match = (meta_ack_num == snd_nxt_q);

  // Decide the connection's reaction to the record currently offered.
  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    nxt_state       = state;
    nxt_rcv_nxt     = rcv_nxt_q;
    nxt_snd_nxt     = snd_nxt_q;
    nxt_peer_port   = peer_port_q;
    nxt_peer_window = peer_window_q;
    do_commit       = 1'b0;
    tx_push         = 1'b0;
    tx_new          = '0;
    data_step       = 1'b0;
    rcv_after       = '0;

    if (!state_legal) begin
      nxt_state = ST_LISTEN;
    end else if (seg_ok) begin
      unique case (state)
        ST_LISTEN: begin
          if (f_syn && !f_ack && !f_rst) begin
            nxt_peer_port = meta_src_port;
            nxt_rcv_nxt   = meta_seq_num + 32'd1;
            nxt_snd_nxt   = ISS + 32'd1;
            tx_push       = 1'b1;
            tx_new        = '{flags: FLAGS_SYNACK, seq: ISS,
                              ack: meta_seq_num + 32'd1, dst_port: meta_src_port};
            nxt_state     = ST_SYN_RCVD;
          end
        end
        ST_SYN_RCVD: begin
          if (f_rst) begin
            nxt_state = ST_LISTEN;
          end else if (f_ack && ack_match && in_order) begin
            nxt_state = ST_ESTABLISHED;
            data_step = 1'b1;
          end
        end
        ST_ESTABLISHED: begin
          if (f_rst) begin
            nxt_state = ST_LISTEN;
          end else if (in_order) begin
            data_step = 1'b1;
          end else begin
            tx_push = 1'b1;
            tx_new  = '{flags: FLAGS_ACK, seq: snd_nxt_q,
                        ack: rcv_nxt_q, dst_port: peer_port_q};
          end
        end
        ST_LAST_ACK: begin
          if ((f_ack && ack_match) || f_rst) nxt_state = ST_LISTEN;
        end
        default: ;
      endcase
    end

    // In-order data handling shared by ESTABLISHED and the final handshake ACK.
    if (data_step) begin
      nxt_peer_window = meta_window_size;
      rcv_after       = rcv_nxt_q + {16'd0, meta_payload_len};
      do_commit       = (meta_payload_len != 16'd0);
      if (f_fin) begin
        rcv_after   = rcv_after + 32'd1;
        tx_push     = 1'b1;
        tx_new      = '{flags: FLAGS_FINACK, seq: snd_nxt_q,
                        ack: rcv_after, dst_port: peer_port_q};
        nxt_snd_nxt = snd_nxt_q + 32'd1;
        nxt_state   = ST_LAST_ACK;
      end else if (do_commit) begin
        tx_push = 1'b1;
        tx_new  = '{flags: FLAGS_ACK, seq: snd_nxt_q,
                    ack: rcv_after, dst_port: peer_port_q};
      end
      nxt_rcv_nxt = rcv_after;
    end
  end

  // Connection state, sequence registers and the commit/drop pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_LISTEN;
      rcv_nxt_q     <= '0;
      snd_nxt_q     <= '0;
      peer_port_q   <= '0;
      peer_window_q <= '0;
      pkt_commit    <= 1'b0;
      pkt_drop      <= 1'b0;
    end else begin
      pkt_commit <= accept && do_commit;
      pkt_drop   <= accept && !do_commit;
      if (accept || !state_legal) begin
        state         <= nxt_state;
        rcv_nxt_q     <= nxt_rcv_nxt;
        snd_nxt_q     <= nxt_snd_nxt;
        peer_port_q   <= nxt_peer_port;
        peer_window_q <= nxt_peer_window;
      end
    end
  end

  tcp_tx_req_slot u_tx_slot (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (accept && tx_push),
    .push_req (tx_new),
    .valid    (tx_req_valid),
    .ready    (tx_req_ready),
    .req      (tx_cur),
    .empty    (slot_empty)
  );

  assign tx_flags    = tx_cur.flags;
  assign tx_seq      = tx_cur.seq;
  assign tx_ack      = tx_cur.ack;
  assign tx_dst_port = tx_cur.dst_port;
  assign conn_state  = state;
  assign rcv_nxt     = rcv_nxt_q;
  assign peer_window = peer_window_q;

endmodule

// File: tb/tb_tcp_rx_conn_ctrl.sv
// Directed plus randomized bench for tcp_rx_conn_ctrl with a behavioural model.
module tb_tcp_rx_conn_ctrl;

  localparam logic [15:0] LPORT = 16'd80;
  localparam logic [31:0] LISS  = 32'h0000_1000;
  localparam int M_LISTEN = 0, M_SYN_RCVD = 1, M_EST = 2, M_LAST_ACK = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        meta_valid = 1'b0;
  logic        meta_ready;
  logic [15:0] meta_src_port = '0, meta_dst_port = '0;
  logic [31:0] meta_seq_num = '0, meta_ack_num = '0;
  logic [7:0]  meta_flags = '0;
  logic [15:0] meta_window_size = '0, meta_payload_len = '0;
  logic        pkt_commit, pkt_drop, tx_req_valid;
  logic        tx_req_ready = 1'b1;
  logic [7:0]  tx_flags;
  logic [31:0] tx_seq, tx_ack, rcv_nxt;
  logic [15:0] tx_dst_port, peer_window;
  logic [2:0]  conn_state;

  tcp_rx_conn_ctrl #(.LOCAL_PORT(LPORT), .ISS(LISS)) dut (
    .clk(clk), .rst_n(rst_n),
    .meta_valid(meta_valid), .meta_ready(meta_ready),
    .meta_src_port(meta_src_port), .meta_dst_port(meta_dst_port),
    .meta_seq_num(meta_seq_num), .meta_ack_num(meta_ack_num),
    .meta_flags(meta_flags), .meta_window_size(meta_window_size),
    .meta_payload_len(meta_payload_len),
    .pkt_commit(pkt_commit), .pkt_drop(pkt_drop),
    .tx_req_valid(tx_req_valid), .tx_req_ready(tx_req_ready),
    .tx_flags(tx_flags), .tx_seq(tx_seq), .tx_ack(tx_ack),
    .tx_dst_port(tx_dst_port), .conn_state(conn_state),
    .rcv_nxt(rcv_nxt), .peer_window(peer_window)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model of the connection, following the protocol rules directly.
  int          m_state;
  logic [31:0] m_rcv, m_snd;
  logic [15:0] m_peer, m_win;
  bit          e_commit, e_tx;
  logic [7:0]  e_flags;
  logic [31:0] e_seq, e_ack;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = M_LISTEN; m_rcv = 0; m_snd = 0; m_peer = 0; m_win = 0;
    e_commit = 0; e_tx = 0; e_flags = 0; e_seq = 0; e_ack = 0;
  endtask

  task automatic model_step(input logic [15:0] src, dst, input logic [31:0] seq, ack,
                            input logic [7:0] fl, input logic [15:0] win, len);
    bit fin = fl[0], syn = fl[1], rstf = fl[2], ackf = fl[4];
    bit ok  = (dst == LPORT) && (m_state == M_LISTEN || src == m_peer);
    bit data = 0;
    e_commit = 0; e_tx = 0;
    if (ok) begin
      if (m_state == M_LISTEN) begin
        if (syn && !ackf && !rstf) begin
          m_peer = src; m_rcv = seq + 1; m_snd = LISS + 1;
          e_tx = 1; e_flags = 8'h12; e_seq = LISS; e_ack = m_rcv;
          m_state = M_SYN_RCVD;
        end
      end else if (m_state == M_SYN_RCVD) begin
        if (rstf) m_state = M_LISTEN;
        else if (ackf && ack == m_snd && seq == m_rcv) begin
          m_state = M_EST; data = 1;
        end
      end else if (m_state == M_EST) begin
        if (rstf) m_state = M_LISTEN;
        else if (seq == m_rcv) data = 1;
        else begin
          e_tx = 1; e_flags = 8'h10; e_seq = m_snd; e_ack = m_rcv;
        end
      end else begin
        if ((ackf && ack == m_snd) || rstf) m_state = M_LISTEN;
      end
    end
    if (data) begin
      m_win = win;
      m_rcv = m_rcv + 32'(len);
      e_commit = (len > 0);
      if (fin) begin
        m_rcv = m_rcv + 1;
        e_tx = 1; e_flags = 8'h11; e_seq = m_snd; e_ack = m_rcv;
        m_snd = m_snd + 1;
        m_state = M_LAST_ACK;
      end else if (len > 0) begin
        e_tx = 1; e_flags = 8'h10; e_seq = m_snd; e_ack = m_rcv;
      end
    end
  endtask

  // Offer one record, then compare the DUT reaction with the model.
  task automatic send(input string tag, input logic [15:0] src, dst,
                      input logic [31:0] seq, ack, input logic [7:0] fl,
                      input logic [15:0] win, len);
    int budget = 0;
    @(negedge clk);
    while (!meta_ready && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    check({tag, ":meta_ready"}, 32'(meta_ready), 32'd1);
    if (!meta_ready) return;
    meta_src_port = src; meta_dst_port = dst; meta_seq_num = seq;
    meta_ack_num = ack; meta_flags = fl; meta_window_size = win;
    meta_payload_len = len; meta_valid = 1'b1;
    @(posedge clk);
    #1;
    meta_valid = 1'b0;
    model_step(src, dst, seq, ack, fl, win, len);
    check({tag, ":commit"}, 32'(pkt_commit), 32'(e_commit));
    check({tag, ":drop"}, 32'(pkt_drop), 32'(!e_commit));
    check({tag, ":state"}, 32'(conn_state), 32'(m_state));
    check({tag, ":peer_window"}, 32'(peer_window), 32'(m_win));
    if (m_state != M_LISTEN) check({tag, ":rcv_nxt"}, rcv_nxt, m_rcv);
    check({tag, ":tx_valid"}, 32'(tx_req_valid), 32'(e_tx));
    if (e_tx) begin
      check({tag, ":tx_flags"}, 32'(tx_flags), 32'(e_flags));
      check({tag, ":tx_seq"}, tx_seq, e_seq);
      check({tag, ":tx_ack"}, tx_ack, e_ack);
      check({tag, ":tx_dst"}, 32'(tx_dst_port), 32'(m_peer));
    end
    @(posedge clk);
    #1;
    check({tag, ":pulse_clear"}, 32'({pkt_commit, pkt_drop}), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    #2;
    check("rst:state", 32'(conn_state), 32'd0);
    check("rst:rcv_nxt", rcv_nxt, 32'd0);
    check("rst:tx_valid", 32'(tx_req_valid), 32'd0);
    check("rst:pulses", 32'({pkt_commit, pkt_drop}), 32'd0);
    check("rst:meta_ready", 32'(meta_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst:meta_ready_after", 32'(meta_ready), 32'd1);

    // Passive open and data transfer.
    send("syn", 16'd1234, LPORT, 32'h100, 32'h0, 8'h02, 16'h4000, 16'd0);
    send("hs_ack", 16'd1234, LPORT, 32'h101, 32'h1001, 8'h10, 16'h2000, 16'd0);
    send("data", 16'd1234, LPORT, 32'h101, 32'h1001, 8'h18, 16'h2100, 16'd10);
    check("data:rcv_nxt_abs", rcv_nxt, 32'h10B);
    send("ooo", 16'd1234, LPORT, 32'h200, 32'h1001, 8'h18, 16'h2200, 16'd20);
    send("bad_dst", 16'd1234, 16'd81, 32'h10B, 32'h1001, 8'h18, 16'h2300, 16'd4);
    send("bad_src", 16'd999, LPORT, 32'h10B, 32'h1001, 8'h18, 16'h2300, 16'd4);

    // Passive close.
    send("fin", 16'd1234, LPORT, 32'h10B, 32'h1001, 8'h11, 16'h2000, 16'd0);
    check("fin:tx_ack_abs", tx_ack, 32'h10C);
    send("last_ack", 16'd1234, LPORT, 32'h10C, 32'h1002, 8'h10, 16'h2000, 16'd0);

    // Reopen, then hold back the TX builder.
    send("syn2", 16'd2000, LPORT, 32'h5000, 32'h0, 8'h02, 16'h1000, 16'd0);
    send("hs2", 16'd2000, LPORT, 32'h5001, 32'h1001, 8'h10, 16'h1000, 16'd0);
    tx_req_ready = 1'b0;
    send("bp_data", 16'd2000, LPORT, 32'h5001, 32'h1001, 8'h18, 16'h1000, 16'd32);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check("bp:meta_ready", 32'(meta_ready), 32'd0);
      check("bp:tx_valid", 32'(tx_req_valid), 32'd1);
      check("bp:tx_ack", tx_ack, e_ack);
      check("bp:tx_seq", tx_seq, e_seq);
    end
    @(negedge clk);
    tx_req_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp:released", 32'(tx_req_valid), 32'd0);
    check("bp:ready_again", 32'(meta_ready), 32'd1);
    send("rst_est", 16'd2000, LPORT, 32'h5021, 32'h1001, 8'h04, 16'h1000, 16'd0);

    // Sequence wrap through the final handshake ACK carrying data.
    send("syn_wrap", 16'd3000, LPORT, 32'hFFFF_FFFB, 32'h0, 8'h02, 16'h800, 16'd0);
    send("wrap", 16'd3000, LPORT, 32'hFFFF_FFFC, 32'h1001, 8'h18, 16'h800, 16'd8);
    check("wrap:rcv_nxt_abs", rcv_nxt, 32'h0000_0004);

    // Reset while a request is pending.
    tx_req_ready = 1'b0;
    send("pre_rst", 16'd3000, LPORT, 32'h4, 32'h1001, 8'h18, 16'h800, 16'd3);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst:tx_valid", 32'(tx_req_valid), 32'd0);
    check("midrst:state", 32'(conn_state), 32'd0);
    check("midrst:rcv_nxt", rcv_nxt, 32'd0);
    check("midrst:tx_fields", tx_seq | tx_ack | 32'(tx_flags) | 32'(tx_dst_port), 32'd0);
    check("midrst:pulses", 32'({pkt_commit, pkt_drop}), 32'd0);
    model_reset();
    tx_req_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic against the model.
    for (int i = 0; i < 300; i++) begin
      logic [7:0]  fl;
      logic [31:0] sq, ak;
      logic [15:0] sp, dp, ln;
      case ($urandom_range(0, 9))
        0, 1:    fl = 8'h02;
        2:       fl = 8'h04;
        3:       fl = 8'h11;
        4, 5:    fl = 8'h10;
        default: fl = 8'h18;
      endcase
      sq = ($urandom_range(0, 3) != 0) ? m_rcv : $urandom();
      ak = ($urandom_range(0, 1) != 0) ? m_snd : $urandom();
      if ($urandom_range(0, 9) != 0)
        sp = (m_state == M_LISTEN) ? 16'($urandom_range(1000, 1003)) : m_peer;
      else
        sp = 16'($urandom());
      dp = ($urandom_range(0, 9) != 0) ? LPORT : 16'($urandom_range(81, 90));
      ln = 16'($urandom_range(0, 1500));
      send("rand", sp, dp, sq, ak, fl, 16'($urandom()), ln);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
